// File: rtl/sync_filt.sv
// sync_filt: multi-channel level synchroniser with per-channel glitch filter and
// registered rise/fall pulses; sticky rise flags built only with SYNC_FILT_STICKY_EN.
module sync_filt #(
   parameter int            CH       = 4,
   parameter int            STAGES   = 2,
   parameter int            FILT_CYC = 8,
   parameter logic [CH-1:0] INIT     = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CH-1:0] din,
   output logic [CH-1:0] dout,
   output logic [CH-1:0] rise,
   output logic [CH-1:0] fall,
   output logic [CH-1:0] sticky,
   input  logic [CH-1:0] sticky_clr
);

   localparam int            CW      = $clog2(FILT_CYC + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CYC - 1);

   if (STAGES < 2) begin : g_bad_stages
      $fatal(1, "sync_filt: STAGES must be >= 2");
   end
   if (FILT_CYC < 1) begin : g_bad_filt
      $fatal(1, "sync_filt: FILT_CYC must be >= 1");
   end

   logic [CH-1:0] sync_q [STAGES];
   logic [CH-1:0] lvl;
   logic [CW-1:0] cnt_q  [CH];
   logic [CW-1:0] cnt_d  [CH];
   logic [CH-1:0] dout_q, dout_d;
   logic [CH-1:0] rise_q, rise_d;
   logic [CH-1:0] fall_q, fall_d;

   assign lvl = sync_q[STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < STAGES; n++) begin
            sync_q[n] <= INIT;
         end
      end else begin
         sync_q[0] <= din;
         for (int n = 1; n < STAGES; n++) begin
            sync_q[n] <= sync_q[n-1];
         end
      end
   end

   // dout only follows after the synced level disagrees for FILT_CYC cycles
   always_comb begin
      dout_d = dout_q;
      rise_d = '0;
      fall_d = '0;
      for (int i = 0; i < CH; i++) begin
         cnt_d[i] = '0;
         if (lvl[i] != dout_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               dout_d[i] = lvl[i];
               rise_d[i] = lvl[i];
               fall_d[i] = ~lvl[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q <= INIT;
         rise_q <= '0;
         fall_q <= '0;
         for (int i = 0; i < CH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         dout_q <= dout_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         for (int i = 0; i < CH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign dout = dout_q;
   assign rise = rise_q;
   assign fall = fall_q;

`ifdef SYNC_FILT_STICKY_EN
   logic [CH-1:0] sticky_q, sticky_d;

   // a rise coinciding with a clear keeps the flag set
   assign sticky_d = (sticky_q & ~sticky_clr) | rise_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_q <= '0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign sticky = sticky_q;
`else
   logic unused_sticky_clr;

   assign unused_sticky_clr = ^sticky_clr;
   assign sticky            = '0;
`endif

endmodule

// File: tb/tb_sync_filt.sv
// tb_sync_filt: directed scoreboard bench for sync_filt (INIT=0 and INIT=1 copies).
// Expected per-channel {dout,rise,fall,sticky} tuples are queued with target edges.
module tb_sync_filt;

`ifdef SYNC_FILT_STICKY_EN
   localparam logic STK = 1'b1;
`else
   localparam logic STK = 1'b0;
`endif

   typedef struct {
      int         at;
      bit         inst;
      int         ch;
      logic [3:0] v;
      string      tag;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_a, rst_b;
   logic [3:0] din_a, din_b, clr_a, clr_b;
   logic [3:0] dout_a, rise_a, fall_a, stk_a;
   logic [3:0] dout_b, rise_b, fall_b, stk_b;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   sync_filt dut_a (
      .clk(clk), .rst(rst_a), .din(din_a), .dout(dout_a),
      .rise(rise_a), .fall(fall_a), .sticky(stk_a), .sticky_clr(clr_a)
   );

   sync_filt #(.INIT(4'h1)) dut_b (
      .clk(clk), .rst(rst_b), .din(din_b), .dout(dout_b),
      .rise(rise_b), .fall(fall_b), .sticky(stk_b), .sticky_clr(clr_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t       e;
      logic [3:0] obs;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
         e = sb.pop_front();
         if (e.inst)
            obs = {dout_b[e.ch], rise_b[e.ch], fall_b[e.ch], stk_b[e.ch]};
         else
            obs = {dout_a[e.ch], rise_a[e.ch], fall_a[e.ch], stk_a[e.ch]};
         checks++;
         assert (e.at == cyc && obs === e.v) else begin
            errors++;
            $error("FAIL %s edge %0d ch%0d: observed drfs=%b required %b",
                   e.tag, e.at, e.ch, obs, e.v);
         end
      end
   end

   task automatic ex(input int at, input bit inst, input int ch,
                     input logic d, input logic r, input logic f,
                     input logic s, input string tag);
      exp_t e;
      e.at   = at;
      e.inst = inst;
      e.ch   = ch;
      e.v    = {d, r, f, s};
      e.tag  = tag;
      sb.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   int c;

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      din_a = 4'hF;
      din_b = 4'h1;
      clr_a = '0;
      clr_b = '0;
      step(1);

      // reset holds outputs at INIT while inputs are high
      c = cyc;
      for (int e = 1; e <= 3; e++) begin
         for (int ch = 0; ch < 4; ch++) begin
            ex(c + e, 1'b0, ch, 1'b0, 1'b0, 1'b0, 1'b0, "reset_a");
         end
         ex(c + e, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, "reset_b0");
         ex(c + e, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, "reset_b1");
      end
      step(3);
      din_a = 4'h0;
      step(1);
      rst_a = 1'b0;
      rst_b = 1'b0;
      step(2);

      // latency of a clean 0->1 on ch0
      c = cyc;
      din_a[0] = 1'b1;
      ex(c + 9, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "lat_before");
      for (int ch = 0; ch < 4; ch++) begin
         if (ch == 0)
            ex(c + 10, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, "lat_rise");
         else
            ex(c + 10, 1'b0, ch, 1'b0, 1'b0, 1'b0, 1'b0, "lat_other");
      end
      ex(c + 10, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, "init_quiet");
      ex(c + 11, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, "lat_after");
      step(12);

      // 7-cycle pulse on ch1 is rejected
      c = cyc;
      din_a[1] = 1'b1;
      for (int e = 9; e <= 12; e++) begin
         ex(c + e, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, "glitch");
      end
      step(7);
      din_a[1] = 1'b0;
      step(6);

      // held level on ch1 is accepted
      c = cyc;
      din_a[1] = 1'b1;
      ex(c + 9, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, "hold_before");
      ex(c + 10, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, "ch0_steady");
      ex(c + 10, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0, "hold_rise");
      ex(c + 11, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, "hold_after");
      step(12);

      // INIT=1 channel falls after normal latency
      c = cyc;
      din_b[0] = 1'b0;
      ex(c + 9, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, "fall_before");
      ex(c + 10, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, "fall_pulse");
      ex(c + 11, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, "fall_after");
      step(12);

      // sticky set, hold and clear on ch2
      c = cyc;
      din_a[2] = 1'b1;
      ex(c + 10, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0, "stk_rise");
      ex(c + 11, 1'b0, 2, 1'b1, 1'b0, 1'b0, STK, "stk_set");
      ex(c + 14, 1'b0, 2, 1'b1, 1'b0, 1'b0, STK, "stk_hold");
      ex(c + 15, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0, "stk_clr");
      ex(c + 16, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0, "stk_clr2");
      step(14);
      clr_a[2] = 1'b1;
      step(1);
      clr_a[2] = 1'b0;

      c = cyc;
      din_a[2] = 1'b0;
      ex(c + 10, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b0, "stk_fall");
      step(12);

      // rise and clear in the same cycle: set wins
      c = cyc;
      din_a[2] = 1'b1;
      ex(c + 10, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0, "stk_rise2");
      ex(c + 11, 1'b0, 2, 1'b1, 1'b0, 1'b0, STK, "stk_setwins");
      ex(c + 12, 1'b0, 2, 1'b1, 1'b0, 1'b0, STK, "stk_setwins2");
      step(10);
      clr_a[2] = 1'b1;
      step(1);
      clr_a[2] = 1'b0;
      step(2);

      // reset mid-filter on ch3 discards the count
      c = cyc;
      din_a[3] = 1'b1;
      ex(c + 7, 1'b0, 2, 1'b1, 1'b0, 1'b0, STK, "mid_stk_pre");
      ex(c + 8, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "mid_ch0");
      ex(c + 8, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, "mid_stk_rst");
      ex(c + 8, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, "mid_rst");
      ex(c + 12, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, "mid_quiet");
      ex(c + 17, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, "mid_before");
      ex(c + 18, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, "mid_ch0_rise");
      ex(c + 18, 1'b0, 3, 1'b1, 1'b1, 1'b0, 1'b0, "mid_rise");
      ex(c + 19, 1'b0, 2, 1'b1, 1'b0, 1'b0, STK, "mid_stk_set");
      ex(c + 19, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0, "mid_after");
      step(7);
      rst_a = 1'b1;
      step(1);
      rst_a = 1'b0;
      step(12);

      for (int i = 0; i < 40 && sb.size() > 0; i++) begin
         @(posedge clk);
      end
      #2;
      checks++;
      assert (sb.size() === 0) else begin
         errors++;
         $error("FAIL drain: observed %0d pending required 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
